// File: rtl/sobel_gradient_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_gradient_pipe_if
// Description : Window-in / result-out bundle for the Sobel gradient engine.
//               Carries the input handshake, per-window configuration, the
//               result handshake and the edge statistics.
//               Optional macro SOBEL_DIR_EN adds the out_dir direction code.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_gradient_pipe_if #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [9*PIX_W-1:0] p_window;
  logic               cfg_mode;
  logic [OUT_W-1:0]   cfg_threshold;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_mag;
  logic               out_edge;
  logic               clr_count;
  logic [CNT_W-1:0]   edge_count;
`ifdef SOBEL_DIR_EN
  logic [1:0]         out_dir;
`endif

  // Engine side
  modport slave (
    input  in_valid,
    input  p_window,
    input  cfg_mode,
    input  cfg_threshold,
    input  out_ready,
    input  clr_count,
    output in_ready,
    output out_valid,
    output out_mag,
    output out_edge,
    output edge_count
`ifdef SOBEL_DIR_EN
    ,
    output out_dir
`endif
  );

  // Window source / result sink side
  modport master (
    output in_valid,
    output p_window,
    output cfg_mode,
    output cfg_threshold,
    output out_ready,
    output clr_count,
    input  in_ready,
    input  out_valid,
    input  out_mag,
    input  out_edge,
    input  edge_count
`ifdef SOBEL_DIR_EN
    ,
    input  out_dir
`endif
  );

endinterface
`default_nettype wire

// File: rtl/sobel_gradient_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sobel_gradient_pipe
// Description : Three-stage pipelined Sobel gradient engine. One 3x3 window
//               per cycle, global stall driven by the result handshake.
//               S1: signed Gx/Gy, S2: absolute values, S3: L1 or max
//               magnitude with saturation, threshold flag (and direction).
//               A saturating edge-pixel counter tracks accepted edges.
//               Optional macro SOBEL_DIR_EN adds a 2-bit direction code.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_gradient_pipe #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sobel_gradient_pipe_if.slave  bus
);

  // Gradient width (signed), absolute-value width, and a width wide enough
  // to compare the raw magnitude against the saturation limit.
  localparam int GW = PIX_W + 3;
  localparam int AW = PIX_W + 2;
  localparam int MW = (GW > OUT_W) ? GW : OUT_W;
  localparam logic [MW-1:0]    MAG_MAX = MW'((64'd1 << OUT_W) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // --------------------------------------------------------------------------
  // Global stall: every stage moves together whenever the output register is
  // empty or being drained this cycle.
  // --------------------------------------------------------------------------
  logic advance;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // --------------------------------------------------------------------------
  // S1 combinational: zero-extend pixels and form the two Sobel sums.
  // --------------------------------------------------------------------------
  logic signed [GW-1:0] pix [9];
  logic signed [GW-1:0] gx_c;
  logic signed [GW-1:0] gy_c;

  for (genvar k = 0; k < 9; k++) begin : g_pix
    assign pix[k] = signed'(GW'(bus.p_window[k*PIX_W +: PIX_W]));
  end

  // Sobel kernels; intermediate sums stay within GW bits for any pixel value
  always_comb begin
    gx_c = (pix[2] + (pix[5] <<< 1) + pix[8]) - (pix[0] + (pix[3] <<< 1) + pix[6]);
    gy_c = (pix[0] + (pix[1] <<< 1) + pix[2]) - (pix[6] + (pix[7] <<< 1) + pix[8]);
  end

  // --------------------------------------------------------------------------
  // S1 registers: gradients plus the configuration captured with the window.
  // --------------------------------------------------------------------------
  logic                 s1_valid;
  logic signed [GW-1:0] s1_gx;
  logic signed [GW-1:0] s1_gy;
  logic                 s1_mode;
  logic [OUT_W-1:0]     s1_thr;

  // Load stage 1 on advance; bubbles clear the valid bit only
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_gx    <= '0;
      s1_gy    <= '0;
      s1_mode  <= 1'b0;
      s1_thr   <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_gx   <= gx_c;
        s1_gy   <= gy_c;
        s1_mode <= bus.cfg_mode;
        s1_thr  <= bus.cfg_threshold;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2 combinational: magnitudes. The most negative GW-bit value is never
  // produced by the kernels, so the negation cannot overflow AW bits.
  // --------------------------------------------------------------------------
  logic signed [GW-1:0] neg_gx;
  logic signed [GW-1:0] neg_gy;
  logic [AW-1:0]        ax_c;
  logic [AW-1:0]        ay_c;

  // Absolute values of both gradients
  always_comb begin
    neg_gx = -s1_gx;
    neg_gy = -s1_gy;
    ax_c   = s1_gx[GW-1] ? AW'(neg_gx) : AW'(s1_gx);
    ay_c   = s1_gy[GW-1] ? AW'(neg_gy) : AW'(s1_gy);
  end

  // --------------------------------------------------------------------------
  // S2 registers
  // --------------------------------------------------------------------------
  logic             s2_valid;
  logic [AW-1:0]    s2_ax;
  logic [AW-1:0]    s2_ay;
  logic             s2_mode;
  logic [OUT_W-1:0] s2_thr;
`ifdef SOBEL_DIR_EN
  logic             s2_gx_neg;
  logic             s2_gy_neg;
`endif

  // Load stage 2 on advance; signs travel along for the direction code
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s2_valid  <= 1'b0;
      s2_ax     <= '0;
      s2_ay     <= '0;
      s2_mode   <= 1'b0;
      s2_thr    <= '0;
`ifdef SOBEL_DIR_EN
      s2_gx_neg <= 1'b0;
      s2_gy_neg <= 1'b0;
`endif
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ax     <= ax_c;
        s2_ay     <= ay_c;
        s2_mode   <= s1_mode;
        s2_thr    <= s1_thr;
`ifdef SOBEL_DIR_EN
        s2_gx_neg <= s1_gx[GW-1];
        s2_gy_neg <= s1_gy[GW-1];
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // S3 combinational: raw magnitude by captured mode, saturation, threshold.
  // --------------------------------------------------------------------------
  logic [GW-1:0]    sum_c;
  logic [GW-1:0]    max_c;
  logic [GW-1:0]    raw_c;
  logic [MW-1:0]    raw_ext;
  logic [OUT_W-1:0] mag_c;
  logic             edge_c;

  // L1 or max magnitude, clamped to the output range, then thresholded
  always_comb begin
    sum_c   = GW'(s2_ax) + GW'(s2_ay);
    max_c   = (s2_ax >= s2_ay) ? GW'(s2_ax) : GW'(s2_ay);
    raw_c   = s2_mode ? max_c : sum_c;
    raw_ext = MW'(raw_c);
    mag_c   = (raw_ext > MAG_MAX) ? OUT_W'(MAG_MAX) : OUT_W'(raw_ext);
    edge_c  = (mag_c >= s2_thr);
  end

`ifdef SOBEL_DIR_EN
  logic [GW-1:0] ax_w;
  logic [GW-1:0] ay_w;
  logic [1:0]    dir_c;

  // Direction bins; the diagonal cases only arise with both gradients nonzero
  always_comb begin
    ax_w = GW'(s2_ax);
    ay_w = GW'(s2_ay);
    if (ax_w >= (ay_w << 1)) begin
      dir_c = 2'd0;
    end else if (ay_w >= (ax_w << 1)) begin
      dir_c = 2'd1;
    end else if (s2_gx_neg == s2_gy_neg) begin
      dir_c = 2'd2;
    end else begin
      dir_c = 2'd3;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // S3 / output registers: held stable while the result waits for out_ready.
  // --------------------------------------------------------------------------
  logic             out_valid_q;
  logic [OUT_W-1:0] out_mag_q;
  logic             out_edge_q;
`ifdef SOBEL_DIR_EN
  logic [1:0]       out_dir_q;
`endif

  // Load the result register on advance; data only changes with a valid result
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_edge_q  <= 1'b0;
`ifdef SOBEL_DIR_EN
      out_dir_q   <= 2'd0;
`endif
    end else if (advance) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_mag_q  <= mag_c;
        out_edge_q <= edge_c;
`ifdef SOBEL_DIR_EN
        out_dir_q  <= dir_c;
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_edge  = out_edge_q;
`ifdef SOBEL_DIR_EN
  assign bus.out_dir   = out_dir_q;
`endif

  // --------------------------------------------------------------------------
  // Edge statistics
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] edge_cnt_q;
  logic             edge_taken;

  assign edge_taken = out_valid_q && bus.out_ready && out_edge_q;

  // Saturating edge counter; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_cnt_q <= '0;
    end else if (bus.clr_count) begin
      edge_cnt_q <= '0;
    end else if (edge_taken && (edge_cnt_q != CNT_MAX)) begin
      edge_cnt_q <= edge_cnt_q + CNT_W'(1);
    end
  end

  assign bus.edge_count = edge_cnt_q;

endmodule
`default_nettype wire
